// File: rtl/irq_ctrl_pkg.sv
// Shared definitions for the irq_ctrl interrupt controller: register offsets,
// FSM state encoding and a small index-to-one-hot helper.
package irq_ctrl_pkg;

  localparam logic [1:0] OFF_PEND = 2'd0;
  localparam logic [1:0] OFF_MASK = 2'd1;
  localparam logic [1:0] OFF_VEC  = 2'd2;
  localparam logic [1:0] OFF_ACK  = 2'd3;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ASSERT = 2'd1,
    GAP    = 2'd2
  } irq_state_e;

  function automatic logic [7:0] idx_onehot(input logic [2:0] idx);
    return 8'd1 << idx;
  endfunction

endpackage

// File: rtl/irq_prio_enc.sv
// Combinational lowest-index-first priority encoder over 8 requests.
module irq_prio_enc (
  input  logic [7:0] req_i,
  output logic [2:0] idx_o,
  output logic       valid_o
);

  // Scan from the top down so the lowest set index wins.
  always_comb begin
    idx_o   = 3'd0;
    valid_o = |req_i;
    for (int i = 7; i >= 0; i--) begin
      if (req_i[i]) begin
        idx_o = 3'(i);
      end else begin
        idx_o = idx_o;
      end
    end
  end

endmodule

// File: rtl/irq_ctrl.sv
// 8-source edge-triggered interrupt controller with PEND/MASK/VEC/ACK I/O registers.
// Optional macro IRQ_CTRL_SYNC_EN adds a 2-flop synchronizer on each source.
module irq_ctrl
  import irq_ctrl_pkg::*;
#(
  parameter logic [7:0] BASE_ADDR = 8'hF0
) (
  input  logic       clk_i,
  input  logic       rst_i,
  input  logic [7:0] src_i,
  input  logic [7:0] io_addr_i,
  input  logic [7:0] io_data_i,
  input  logic       io_we_i,
  output logic [7:0] io_data_o,
  output logic       irq_o
);

  logic [7:0] src_s, edge_s, clr_s, off_s, req_s, rdata_s;
  logic [7:0] prev_q, pend_q, pend_d, mask_q, mask_d;
  logic [2:0] idx_q, idx_d, enc_idx_s;
  logic       first_q, act_q, act_d, irq_q, irq_d;
  logic       hit_s, wr_s, ack_s, enc_valid_s;
  irq_state_e state_q, state_d;

`ifdef IRQ_CTRL_SYNC_EN
  logic [7:0] sync1_q, sync2_q;

  // Free-running so a source held high through reset is already settled at release.
  always_ff @(posedge clk_i) begin
    sync1_q <= src_i;
    sync2_q <= sync1_q;
  end

  assign src_s = sync2_q;
`else
  assign src_s = src_i;
`endif

  assign off_s  = io_addr_i - BASE_ADDR;
  assign hit_s  = (off_s < 8'd4);
  assign wr_s   = io_we_i && hit_s;
  assign ack_s  = wr_s && (off_s[1:0] == OFF_ACK) && (state_q == ASSERT);
  // first_q suppresses detection on the cycle after reset so held-high sources count as old.
  assign edge_s = src_s & ~prev_q & ~{8{first_q}};
  assign req_s  = pend_q & mask_q;

  irq_prio_enc u_prio (
    .req_i   (req_s),
    .idx_o   (enc_idx_s),
    .valid_o (enc_valid_s)
  );

  // PEND/MASK next state; a new edge beats any clear on the same bit.
  always_comb begin
    clr_s  = 8'h00;
    mask_d = mask_q;
    if (wr_s && (off_s[1:0] == OFF_PEND)) begin
      clr_s = io_data_i;
    end else begin
      clr_s = 8'h00;
    end
    if (ack_s) begin
      clr_s = clr_s | idx_onehot(idx_q);
    end else begin
      clr_s = clr_s;
    end
    if (wr_s && (off_s[1:0] == OFF_MASK)) begin
      mask_d = io_data_i;
    end else begin
      mask_d = mask_q;
    end
    pend_d = (pend_q & ~clr_s) | edge_s;
  end

  // Request FSM; irq_o follows ASSERT one cycle late and drops on the ACK edge.
  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    act_d   = act_q;
    irq_d   = 1'b0;
    case (state_q)
      IDLE: begin
        if (enc_valid_s) begin
          state_d = ASSERT;
          idx_d   = enc_idx_s;
          act_d   = 1'b1;
        end else begin
          state_d = IDLE;
        end
      end
      ASSERT: begin
        irq_d = !ack_s;
        if (ack_s) begin
          state_d = GAP;
          act_d   = 1'b0;
        end else begin
          state_d = ASSERT;
        end
      end
      GAP:     state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // State and register update with synchronous reset.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      prev_q  <= 8'h00;
      first_q <= 1'b1;
      pend_q  <= 8'h00;
      mask_q  <= 8'h00;
      idx_q   <= 3'd0;
      act_q   <= 1'b0;
      irq_q   <= 1'b0;
      state_q <= IDLE;
    end else begin
      prev_q  <= src_s;
      first_q <= 1'b0;
      pend_q  <= pend_d;
      mask_q  <= mask_d;
      idx_q   <= idx_d;
      act_q   <= act_d;
      irq_q   <= irq_d;
      state_q <= state_d;
    end
  end

  // Combinational read mux; ACK and undecoded addresses read as zero.
  always_comb begin
    rdata_s = 8'h00;
    if (hit_s) begin
      case (off_s[1:0])
        OFF_PEND: rdata_s = pend_q;
        OFF_MASK: rdata_s = mask_q;
        OFF_VEC:  rdata_s = {act_q, 4'b0000, idx_q};
        default:  rdata_s = 8'h00;
      endcase
    end else begin
      rdata_s = 8'h00;
    end
  end

  assign io_data_o = rdata_s;
  assign irq_o     = irq_q;

endmodule

// File: tb/tb_irq_ctrl.sv
// Directed plus randomized bench for irq_ctrl with a request-level reference model.
module tb_irq_ctrl;

  localparam logic [7:0] BASE = 8'hF0;

  logic       clk_i = 1'b0;
  logic       rst_i;
  logic [7:0] src_i, io_addr_i, io_data_i, io_data_o;
  logic       io_we_i, irq_o;

  int checks = 0;
  int errors = 0;

  // reference model state (request level, not FSM level)
  logic [7:0] m_pend, m_mask, m_prev;
  bit         m_first;
  int         m_served, m_age, m_idx, m_gap;

  irq_ctrl #(.BASE_ADDR(BASE)) dut (
    .clk_i     (clk_i),
    .rst_i     (rst_i),
    .src_i     (src_i),
    .io_addr_i (io_addr_i),
    .io_data_i (io_data_i),
    .io_we_i   (io_we_i),
    .io_data_o (io_data_o),
    .irq_o     (irq_o)
  );

  always #5 clk_i = ~clk_i;

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: got %h want %h", tag, obs, exp);
    end
  endtask

  function automatic logic [7:0] model_rd(input int off);
    case (off)
      0:       return m_pend;
      1:       return m_mask;
      2:       return {(m_served >= 0), 4'b0000, 3'(m_idx)};
      default: return 8'h00;
    endcase
  endfunction

  // advance the model using the inputs present at the coming edge, then clock and check irq
  task automatic tick();
    logic [7:0] edges, clr, req, new_mask;
    bit ack;
    if (rst_i) begin
      m_pend = 8'h00; m_mask = 8'h00; m_prev = 8'h00; m_first = 1'b1;
      m_served = -1; m_age = 0; m_idx = 0; m_gap = 0;
    end else begin
      edges    = m_first ? 8'h00 : (src_i & ~m_prev);
      m_prev   = src_i;
      m_first  = 1'b0;
      clr      = 8'h00;
      new_mask = m_mask;
      ack      = io_we_i && (io_addr_i == BASE + 8'd3) && (m_served >= 0);
      if (io_we_i && io_addr_i == BASE) clr = io_data_i;
      if (io_we_i && io_addr_i == BASE + 8'd1) new_mask = io_data_i;
      req = m_pend & m_mask;
      if (ack) begin
        clr[m_served] = 1'b1;
        m_served = -1;
        m_gap = 1;
      end else if (m_served >= 0) begin
        m_age++;
      end else if (m_gap > 0) begin
        m_gap--;
      end else if (req != 8'h00) begin
        for (int i = 7; i >= 0; i--) if (req[i]) m_served = i;
        m_idx = m_served;
        m_age = 0;
      end
      m_pend = (m_pend & ~clr) | edges;
      m_mask = new_mask;
    end
    @(posedge clk_i);
    #1;
    chk("irq", {7'b0, irq_o}, {7'b0, (m_served >= 0 && m_age >= 1)});
  endtask

  task automatic wr(input int off, input logic [7:0] data);
    io_addr_i = BASE + 8'(off);
    io_data_i = data;
    io_we_i   = 1'b1;
    tick();
    io_we_i   = 1'b0;
    io_data_i = 8'h00;
  endtask

  task automatic rd(input int off, input logic [7:0] exp, input string tag);
    io_addr_i = BASE + 8'(off);
    #1;
    chk(tag, io_data_o, exp);
  endtask

  initial begin
    rst_i = 1'b1; src_i = 8'h00; io_addr_i = 8'h00; io_data_i = 8'h00; io_we_i = 1'b0;
    tick(); tick();
    rst_i = 1'b0;
    rd(0, 8'h00, "rst_pend"); rd(1, 8'h00, "rst_mask"); rd(2, 8'h00, "rst_vec");

    // single masked-in edge, two-clock latency, vector read
    wr(1, 8'h04);
    src_i = 8'h04; tick();
    rd(0, 8'h04, "e030_pend");
    chk("e030_irq_k", {7'b0, irq_o}, 8'h00);
    tick(); chk("e030_irq_k1", {7'b0, irq_o}, 8'h00);
    tick(); chk("e030_irq_k2", {7'b0, irq_o}, 8'h01);
    rd(2, 8'h82, "e030_vec");
    wr(3, 8'h00); chk("e030_ack_irq", {7'b0, irq_o}, 8'h00);
    src_i = 8'h00; tick();

    // two simultaneous edges served in priority order with a gap
    wr(1, 8'hFF);
    src_i = 8'h28; tick(); tick(); tick();
    rd(2, 8'h83, "e031_vec1");
    wr(3, 8'h00); rd(2, 8'h03, "e031_vec_ack");
    tick(); chk("e031_gap_irq", {7'b0, irq_o}, 8'h00);
    tick(); chk("e031_idle_irq", {7'b0, irq_o}, 8'h00);
    tick(); chk("e031_irq2", {7'b0, irq_o}, 8'h01);
    rd(2, 8'h85, "e031_vec2");
    wr(3, 8'h00); src_i = 8'h00; tick(); tick(); tick();

    // masked source pends, unmasking triggers request
    wr(1, 8'h00);
    src_i = 8'h80; tick(); tick(); tick();
    rd(0, 8'h80, "e032_pend");
    chk("e032_masked_irq", {7'b0, irq_o}, 8'h00);
    wr(1, 8'h80); tick(); chk("e032_irq_k1", {7'b0, irq_o}, 8'h00);
    tick(); chk("e032_irq_k2", {7'b0, irq_o}, 8'h01);
    wr(3, 8'h00); src_i = 8'h00; tick(); tick();

    // set wins over W1C in the same cycle
    wr(1, 8'h00);
    src_i = 8'h02; wr(0, 8'h02);
    rd(0, 8'h02, "e033_set_wins");
    wr(0, 8'h02);
    rd(0, 8'h00, "e033_w1c");

    // reset mid-ASSERT, held-high sources give no new edge
    wr(1, 8'hFF);
    src_i = 8'h11; tick(); tick(); tick();
    chk("e034_assert", {7'b0, irq_o}, 8'h01);
    rd(0, 8'h11, "e034_pend");
    rst_i = 1'b1; tick(); rst_i = 1'b0;
    rd(0, 8'h00, "e034_pend_rst"); rd(1, 8'h00, "e034_mask_rst");
    chk("e034_irq_rst", {7'b0, irq_o}, 8'h00);
    wr(1, 8'hFF); tick(); tick(); tick();
    chk("e034_no_req", {7'b0, irq_o}, 8'h00);
    rd(0, 8'h00, "e034_no_pend");

    // decode boundaries and ACK ignored while IDLE
    rd(4, 8'h00, "e035_base4"); rd(3, 8'h00, "e035_base3");
    io_addr_i = BASE - 8'd1; #1; chk("e035_below", io_data_o, 8'h00);
    wr(1, 8'h00);
    src_i = 8'h00; tick();
    src_i = 8'h08; tick();
    wr(1, 8'h08);
    wr(3, 8'h00);
    tick(); chk("e035_idle_ack", {7'b0, irq_o}, 8'h01);
    rd(2, 8'h83, "e035_vec");
    wr(3, 8'h00); tick(); tick();

    // randomized traffic against the model
    for (int n = 0; n < 400; n++) begin
      int r;
      if ($urandom_range(0, 2) == 0) src_i = 8'($urandom);
      r = $urandom_range(0, 19);
      rst_i = (r == 0) && ($urandom_range(0, 3) == 0);
      io_data_i = 8'($urandom);
      io_we_i   = 1'b0;
      if (r == 1 || r == 2) begin io_addr_i = BASE + 8'd1; io_we_i = 1'b1; end
      else if (r == 3) begin io_addr_i = BASE; io_we_i = 1'b1; end
      else if (r == 4) begin io_addr_i = BASE + 8'd4; io_we_i = 1'b1; end
      else if (r >= 14 || (r == 5)) begin io_addr_i = BASE + 8'd3; io_we_i = 1'b1; end
      tick();
      io_we_i = 1'b0;
      rst_i   = 1'b0;
      for (int o = 0; o < 5; o++) rd(o, model_rd(o), "rand_rd");
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/irq_ctrl.md
IRQ_CTRL -- requirements
Module: irq_ctrl

Interface
REQ-001 SHALL have parameter BASE_ADDR, default 8'hF0, meaning the I/O port address of register offset 0; the block decodes BASE_ADDR..BASE_ADDR+3.
REQ-002 SHALL have port clk_i  input  1  system clock; all logic on its rising edge.
REQ-003 SHALL have port rst_i  input  1  reset; one clock, synchronous, active-high.
REQ-004 SHALL have port src_i  input  8  interrupt sources; bit 0 has highest priority.
REQ-005 SHALL have port io_addr_i  input  8  I/O port address, driven by core io_addr_o.
REQ-006 SHALL have port io_data_i  input  8  I/O write data, driven by core io_data_o.
REQ-007 SHALL have port io_we_i  input  1  I/O write strobe, driven by core io_we_o.
REQ-008 SHALL have port io_data_o  output  8  I/O read data, OR-combined onto core io_data_i.
REQ-009 SHALL have port irq_o  output  1  interrupt request to core irq_i; the core is rising-edge sensitive.

Function
REQ-010 SHALL detect rising edges only: a bit is sampled high with its previous sample low -> PEND[i] set on that same clock edge.
REQ-011 SHALL implement registers: +0 PEND (read; write-1-to-clear), +1 MASK (read/write), +2 VEC (read-only {ACT, 4'b0, IDX[2:0]}), +3 ACK (write-only, data ignored).
REQ-012 SHALL make io_data_o combinational from io_addr_i; it is 8'h00 for any address outside the four decoded registers and for +3.
REQ-013 SHALL act on writes only in a cycle with io_we_i=1 and a matching address; each write cycle is one single-cycle strobe.
REQ-014 SHALL use FSM states IDLE, ASSERT and GAP; irq_o is registered and is 1 only in ASSERT.
REQ-015 SHALL, in IDLE, move to ASSERT when (PEND & MASK) != 0, latching IDX = lowest set index of (PEND & MASK) and setting ACT=1.
REQ-016 SHALL remain in ASSERT, with IDX frozen, until an ACK write; mask or PEND changes in ASSERT have no effect on IDX.
REQ-017 SHALL, on an ACK write in ASSERT, clear PEND[IDX], clear ACT and move to GAP; an ACK write outside ASSERT is ignored.
REQ-018 SHALL stay in GAP for exactly one cycle with irq_o=0, then return to IDLE, so every request gives a fresh rising edge.
REQ-019 SHALL give latency: edge detected at clock k -> irq_o=1 from clock k+2 (IDLE->ASSERT at k+1, output register at k+2).
REQ-020 SHALL resolve simultaneous set (edge) and clear (W1C or ACK) on one PEND bit as set; PEND bit stays 1.
REQ-021 SHALL ignore an edge on a bit that is already pending, with no counting and no overflow.
REQ-022 SHALL let a masked source still set PEND; unmasking later triggers the request.

Reset
REQ-023 SHALL, with rst_i=1, set PEND=0, MASK=0, IDX=0, ACT=0, state=IDLE, irq_o=0 and the edge history to 0 on the next clock edge.
REQ-024 SHALL abandon any request on reset mid-ASSERT; no ACK is needed afterwards.
REQ-025 SHALL hold src_i sources that are high at reset release as "previous high", so they do not create an edge.

Configuration
REQ-026 SHALL, with macro IRQ_CTRL_SYNC_EN defined, pass each src_i bit through a 2-flop synchronizer before edge detection, adding 2 cycles to REQ-019 latency (irq_o at k+4 from the src_i sampling edge).
REQ-027 SHALL, without IRQ_CTRL_SYNC_EN, sample src_i directly; sources must then be synchronous to clk_i.

Structure
REQ-028 SHALL put register offsets (PEND=0, MASK=1, VEC=2, ACK=3) and the FSM state enum in package irq_ctrl_pkg.
REQ-029 SHALL implement the lowest-index-first priority selection as sub-module irq_prio_enc (8-bit request in; 3-bit index and valid out; combinational).

Verification
REQ-030 SHALL cover: MASK<=8'h04; rising edge on src_i[2] -> PEND=8'h04, irq_o 0->1 two clocks later, VEC reads 8'h82.
REQ-031 SHALL cover: MASK=8'hFF; src_i 8'h00->8'h28 in one cycle -> VEC=8'h83; ACK -> one GAP cycle with irq_o=0; irq_o rises again; VEC=8'h85.
REQ-032 SHALL cover: MASK=8'h00; edge on src_i[7] -> PEND=8'h80 and irq_o stays 0; MASK<=8'h80 -> irq_o=1 two clocks later.
REQ-033 SHALL cover: in a cycle with an edge on src_i[1], write 8'h02 to PEND -> PEND[1] stays 1; with no edge, write 8'h02 -> PEND[1]=0.
REQ-034 SHALL cover: rst_i pulsed in ASSERT with PEND=8'h11 -> PEND=0, MASK=0, irq_o=0; src_i held high with no new edge -> no request.
REQ-035 SHALL cover: read at BASE_ADDR+4 and at BASE_ADDR+3 -> io_data_o=8'h00; ACK write in IDLE -> no state change.
